// File: rtl/mc_state_sequencer.sv
// mc_state_sequencer: multi-cycle instruction sequencer driving a CPU output-function decoder.
// Optional feature: define SEQ_PERF_CNT_EN to add the cycle_cnt / retired_cnt performance counters.
module mc_state_sequencer (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_AEXE = 3'b110,
        S_BEXE = 3'b101,
        S_CEXE = 3'b010,
        S_MEM  = 3'b011,
        S_AWB  = 3'b111,
        S_CWB  = 3'b100
    } state_t;

    typedef enum logic [2:0] {
        C_JUMP,
        C_BRANCH,
        C_ALU,
        C_STORE,
        C_LOAD,
        C_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t    cur_state;
    state_t    next_state;
    op_class_t op_class;
    logic      done_next;
    logic      illegal_next;
    logic      halt_set;

    // Sort the opcode into the execution path it takes through the FSM.
    always_comb begin
        op_class = C_ILLEGAL;
        case (opcode)
            OP_J, OP_JR, OP_JAL, OP_HALT:                    op_class = C_JUMP;
            OP_BEQ:                                          op_class = C_BRANCH;
            OP_ADDI, OP_ORI, OP_SLL, OP_ADD, OP_SUB,
            OP_SLT, OP_SLTI, OP_OR, OP_AND:                  op_class = C_ALU;
            OP_SW:                                           op_class = C_STORE;
            OP_LW:                                           op_class = C_LOAD;
            default:                                         op_class = C_ILLEGAL;
        endcase
    end

    // Next-state logic plus the values the registered flags take on the next edge.
    always_comb begin
        next_state   = S_IF;
        illegal_next = 1'b0;
        halt_set     = 1'b0;
        case (cur_state)
            S_IF:   next_state = halted ? S_IF : S_ID;
            S_ID: begin
                case (op_class)
                    C_JUMP: begin
                        next_state = S_IF;
                        halt_set   = (opcode == OP_HALT);
                    end
                    C_BRANCH:        next_state = S_BEXE;
                    C_ALU:           next_state = S_AEXE;
                    C_STORE, C_LOAD: next_state = S_CEXE;
                    default: begin
                        next_state   = S_IF;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_AEXE: next_state = S_AWB;
            S_AWB:  next_state = S_IF;
            S_BEXE: next_state = S_IF;
            S_CEXE: next_state = S_MEM;
            S_MEM: begin
                if (!mem_ready)
                    next_state = S_MEM;
                else if (op_class == C_LOAD)
                    next_state = S_CWB;
                else
                    next_state = S_IF;
            end
            S_CWB:  next_state = S_IF;
            default: next_state = S_IF;
        endcase
        done_next = (next_state == S_IF) && (cur_state != S_IF);
    end

    // State register and registered status flags; halted is sticky until reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cur_state  <= S_IF;
            instr_done <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            cur_state  <= next_state;
            instr_done <= done_next;
            illegal    <= illegal_next;
            if (halt_set)
                halted <= 1'b1;
        end
    end

    assign state = cur_state;

`ifdef SEQ_PERF_CNT_EN
    // Performance counters: running cycles and retired instructions, both free-wrapping.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt   <= 32'd0;
            retired_cnt <= 32'd0;
        end else begin
            if (!halted)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done)
                retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_state_sequencer.sv
// tb_mc_state_sequencer: directed plus randomized instruction streams checked against
// a path-list reference model of the sequencer.
module tb_mc_state_sequencer;

    localparam logic [2:0] S_IF   = 3'b000;
    localparam logic [2:0] S_ID   = 3'b001;
    localparam logic [2:0] S_AEXE = 3'b110;
    localparam logic [2:0] S_BEXE = 3'b101;
    localparam logic [2:0] S_CEXE = 3'b010;
    localparam logic [2:0] S_MEM  = 3'b011;
    localparam logic [2:0] S_AWB  = 3'b111;
    localparam logic [2:0] S_CWB  = 3'b100;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam int CLS_JUMP    = 0;
    localparam int CLS_BRANCH  = 1;
    localparam int CLS_ALU     = 2;
    localparam int CLS_STORE   = 3;
    localparam int CLS_LOAD    = 4;
    localparam int CLS_ILLEGAL = 5;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic [2:0]  state;
    logic        instr_done;
    logic        halted;
    logic        illegal;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] retired_cnt;
`endif

    int passCount = 0;
    int checkCount = 0;

    // Model of the visible registered flags and counters.
    logic        prev_done = 1'b0;
    logic        prev_halted = 1'b0;
    logic [31:0] model_cyc = 32'd0;
    logic [31:0] model_ret = 32'd0;

    logic [5:0] legal_ops [15] = '{6'b000010, 6'b010010, 6'b011000, 6'b000000, 6'b000001,
                                   6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
                                   6'b111000, 6'b111001, 6'b010000, 6'b010001, 6'b111010};

    mc_state_sequencer dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .state      (state),
        .instr_done (instr_done),
        .halted     (halted),
        .illegal    (illegal)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retired_cnt(retired_cnt)
`endif
    );

    // Free-running clock.
    always #5 CLK = ~CLK;

    function automatic int classOf(input logic [5:0] op);
        case (op)
            6'b111000, 6'b111001, 6'b111010, 6'b111111: return CLS_JUMP;
            6'b110100:                                  return CLS_BRANCH;
            6'b000010, 6'b010010, 6'b011000, 6'b000000, 6'b000001,
            6'b100110, 6'b100111, 6'b010000, 6'b010001: return CLS_ALU;
            6'b110000:                                  return CLS_STORE;
            6'b110001:                                  return CLS_LOAD;
            default:                                    return CLS_ILLEGAL;
        endcase
    endfunction

    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount = passCount + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkAll(input string tag, input logic [2:0] exp_state, input logic exp_done,
                            input logic exp_illegal, input logic exp_halted);
        checkOutput({tag, ".state"}, 32'(state), 32'(exp_state));
        checkOutput({tag, ".instr_done"}, 32'(instr_done), 32'(exp_done));
        checkOutput({tag, ".illegal"}, 32'(illegal), 32'(exp_illegal));
        checkOutput({tag, ".halted"}, 32'(halted), 32'(exp_halted));
`ifdef SEQ_PERF_CNT_EN
        checkOutput({tag, ".cycle_cnt"}, cycle_cnt, model_cyc);
        checkOutput({tag, ".retired_cnt"}, retired_cnt, model_ret);
`endif
    endtask

    // One clock edge: advance the counter model from the flags visible before the edge.
    task automatic stepAndCheck(input string tag, input logic [2:0] exp_state, input logic exp_done,
                                input logic exp_illegal, input logic exp_halted);
        if (!prev_halted) model_cyc = model_cyc + 32'd1;
        if (prev_done)    model_ret = model_ret + 32'd1;
        applyStimulus();
        prev_done   = exp_done;
        prev_halted = exp_halted;
        checkAll(tag, exp_state, exp_done, exp_illegal, exp_halted);
    endtask

    task automatic doReset(input string tag);
        Reset = 1'b1;
        applyStimulus();
        model_cyc   = 32'd0;
        model_ret   = 32'd0;
        prev_done   = 1'b0;
        prev_halted = 1'b0;
        Reset = 1'b0;
        checkAll(tag, S_IF, 1'b0, 1'b0, 1'b0);
    endtask

    // Run one instruction from IF back to IF, comparing every cycle with its class path.
    task automatic runInstruction(input string tag, input logic [5:0] op, input int stalls);
        logic [2:0] path [$];
        int cls;
        int mem_seen;
        logic last;
        cls = classOf(op);
        path = {};
        path.push_back(S_ID);
        case (cls)
            CLS_BRANCH: path.push_back(S_BEXE);
            CLS_ALU: begin
                path.push_back(S_AEXE);
                path.push_back(S_AWB);
            end
            CLS_STORE, CLS_LOAD: begin
                path.push_back(S_CEXE);
                for (int k = 0; k <= stalls; k++) path.push_back(S_MEM);
                if (cls == CLS_LOAD) path.push_back(S_CWB);
            end
            default: ;
        endcase
        path.push_back(S_IF);
        opcode = op;
        mem_seen = 0;
        for (int i = 0; i < path.size(); i++) begin
            if (i > 0 && path[i-1] == S_MEM) begin
                mem_ready = (mem_seen == stalls);
                mem_seen++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            last = (i == path.size() - 1);
            stepAndCheck(tag, path[i], last, last && (cls == CLS_ILLEGAL),
                         prev_halted || (last && op == OP_HALT));
        end
    endtask

    initial begin
        logic [5:0] op;
        $display("[TB] starting mc_state_sequencer bench");

        // Power-up reset held for two edges.
        Reset = 1'b1;
        applyStimulus();
        doReset("reset");

        // Directed instruction classes.
        runInstruction("add", OP_ADD, 0);
        runInstruction("lw_stall3", OP_LW, 3);
        runInstruction("sw", OP_SW, 0);
        runInstruction("beq", OP_BEQ, 0);
        runInstruction("j", OP_J, 0);
        runInstruction("illegal_2a", 6'b101010, 0);

        // Randomized instruction stream, occasionally undecodable.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (classOf(op) != CLS_ILLEGAL);
            end else begin
                op = legal_ops[$urandom_range(0, 14)];
            end
            runInstruction("random", op, int'($urandom_range(0, 4)));
        end

        // Reset while stalled in MEM.
        opcode = OP_LW;
        mem_ready = 1'b0;
        stepAndCheck("mem_rst_id", S_ID, 1'b0, 1'b0, 1'b0);
        stepAndCheck("mem_rst_cexe", S_CEXE, 1'b0, 1'b0, 1'b0);
        stepAndCheck("mem_rst_mem", S_MEM, 1'b0, 1'b0, 1'b0);
        stepAndCheck("mem_rst_mem2", S_MEM, 1'b0, 1'b0, 1'b0);
        doReset("mem_reset");
        runInstruction("after_mem_reset", OP_ADD, 0);

        // Halt, then idle with noisy inputs: nothing may move.
        runInstruction("halt", OP_HALT, 0);
        for (int n = 0; n < 22; n++) begin
            opcode = 6'($urandom);
            mem_ready = 1'($urandom_range(0, 1));
            stepAndCheck("halt_idle", S_IF, 1'b0, 1'b0, 1'b1);
        end
        doReset("halt_reset");
        runInstruction("after_halt", OP_ADD, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mc_state_sequencer.md
MC_STATE_SEQUENCER -- requirements
Module: mc_state_sequencer

Interface
REQ-001 The block SHALL have a single clock domain with a synchronous, active-high reset.
REQ-002 Port CLK, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port opcode, input, 6 bits: instruction opcode from IR, stable from ID until the next IF.
REQ-005 Port mem_ready, input, 1 bit: data memory access complete; sampled only in MEM.
REQ-006 Port state, output, 3 bits: current state, registered; drives the output-function decoder.
REQ-007 Port instr_done, output, 1 bit: registered one-cycle pulse in the cycle the FSM re-enters IF after completing an instruction.
REQ-008 Port halted, output, 1 bit: registered sticky flag, set after a halt instruction.
REQ-009 Port illegal, output, 1 bit: registered one-cycle pulse flagging an undecodable opcode.
REQ-010 With SEQ_PERF_CNT_EN defined, port cycle_cnt, output, 32 bits: counts non-halted cycles.
REQ-011 With SEQ_PERF_CNT_EN defined, port retired_cnt, output, 32 bits: counts completed instructions.

Function
REQ-012 State encodings SHALL be IF=000, ID=001, aEXE=110, bEXE=101, cEXE=010, MEM=011, aWB=111, cWB=100.
REQ-013 Opcodes SHALL be addi=000010, ori=010010, sll=011000, add=000000, sub=000001, slt=100110, slti=100111, sw=110000, lw=110001, beq=110100, j=111000, jr=111001, or=010000, and=010001, jal=111010, halt=111111.
REQ-014 The IF state SHALL go to ID when halted=0, and SHALL remain in IF when halted=1.
REQ-015 The ID state SHALL go to IF for j, jr, jal or halt.
REQ-016 The ID state SHALL go to bEXE for beq.
REQ-017 The ID state SHALL go to cEXE for sw or lw.
REQ-018 The ID state SHALL go to aEXE for addi, ori, sll, add, sub, slt, slti, or and and.
REQ-019 The ID state SHALL go to IF and pulse illegal for any other opcode.
REQ-020 Transitions SHALL be aEXE->aWB, aWB->IF, bEXE->IF, cEXE->MEM and cWB->IF.
REQ-021 The MEM state SHALL remain in MEM while mem_ready=0; with mem_ready=1 it SHALL go to IF for sw and to cWB for lw.
REQ-022 The MEM wait SHALL be unbounded, with no timeout.
REQ-023 An unencoded state value SHALL recover to IF on the next edge.
REQ-024 halted SHALL set in the cycle the ID-to-IF transition on halt occurs, and clear only on Reset.
REQ-025 instr_done SHALL be 1 in exactly the one cycle after any transition into IF, including halt and illegal.
REQ-026 instr_done SHALL never assert while the FSM idles in IF with halted=1.
REQ-027 Each instruction class SHALL have a fixed latency, mem_ready stalls excluded, with instr_done rising that many cycles after leaving IF: j/jr/jal/halt 2 cycles, beq 3, R/I-type ALU 4, sw 4, lw 5.
REQ-028 All outputs SHALL be registered, with no combinational path from an input to any output.

Reset
REQ-029 Reset=1 at a rising edge SHALL force state=IF, instr_done=0, halted=0, illegal=0 and, if SEQ_PERF_CNT_EN is defined, cycle_cnt=0 and retired_cnt=0.
REQ-030 Reset SHALL take priority over every transition, including the MEM wait and the halted condition.
REQ-031 The cycle after Reset deasserts SHALL be IF; when halted=0 it SHALL go to ID on the next edge.

Configuration
REQ-032 With SEQ_PERF_CNT_EN defined, cycle_cnt SHALL increment every cycle halted=0, and retired_cnt SHALL increment each cycle instr_done=1.
REQ-033 Both counters SHALL wrap from FFFFFFFF to 00000000 without a flag.
REQ-034 Without SEQ_PERF_CNT_EN, the counter ports and logic SHALL be absent, and the FSM behaviour SHALL be identical.

Verification
REQ-035 Reset, then opcode=add (000000) held: the state sequence SHALL be IF, ID, aEXE(110), aWB(111), IF; instr_done=1 in the cycle after aWB; illegal=0.
REQ-036 opcode=lw (110001) with mem_ready=0 for 3 MEM cycles then 1: the sequence SHALL be IF, ID, cEXE, MEM x4, cWB, IF; with SEQ_PERF_CNT_EN, retired_cnt SHALL be 1.
REQ-037 opcode=sw (110000) with mem_ready=1: the sequence SHALL be IF, ID, cEXE, MEM, IF, and the FSM SHALL never enter cWB.
REQ-038 opcode=beq, then j: the sequences SHALL be IF, ID, bEXE(101), IF and IF, ID, IF; instr_done SHALL pulse twice.
REQ-039 opcode=halt (111111): the sequence SHALL be IF, ID, IF, then state=000 held for at least 20 cycles, with halted=1, no further instr_done, and cycle_cnt frozen; Reset SHALL then clear halted.
REQ-040 opcode=101010 (illegal): the sequence SHALL be IF, ID, IF, with illegal=1 for one cycle.
REQ-041 Reset asserted while in MEM with mem_ready=0: the next state SHALL be IF with all outputs at reset values.
